// File: rtl/vector_data_cache_pkg.sv
// Shared request/status codes and FSM state type for the vector data cache.
package vector_data_cache_pkg;

    // Load/store unit request codes
    localparam logic [1:0] D_CACHE_NOP   = 2'd0;
    localparam logic [1:0] D_CACHE_LOAD  = 2'd1;
    localparam logic [1:0] D_CACHE_STORE = 2'd2;

    // Status codes returned to the load/store unit
    localparam logic [1:0] D_CACHE_RESTING = 2'd0;
    localparam logic [1:0] D_CACHE_WORKING = 2'd1;
    localparam logic [1:0] D_CACHE_STALL   = 2'd2;
    localparam logic [1:0] L_S_FINISHED    = 2'd3;

    // Memory request codes
    localparam logic [1:0] MEM_NOP   = 2'd0;
    localparam logic [1:0] MEM_READ  = 2'd1;
    localparam logic [1:0] MEM_WRITE = 2'd2;

    // Memory status codes
    localparam logic [1:0] MEM_RESTING  = 2'd0;
    localparam logic [1:0] MEM_WORKING  = 2'd1;
    localparam logic [1:0] MEM_FINISHED = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StFill,
        StDone
    } vdc_state_e;

endpackage

// File: rtl/vdc_elem_sel.sv
// Finds the lowest active element index at or above from_idx_i.
// An element is active when it lies below the (clamped) length and its mask bit is set.
module vdc_elem_sel #(
    parameter int unsigned VECTOR_SIZE = 8,
    parameter int unsigned LEN_WIDTH   = $clog2(VECTOR_SIZE) + 1
) (
    input  logic [VECTOR_SIZE-1:0]         mask_i,
    input  logic [LEN_WIDTH-1:0]           length_i,
    input  logic [LEN_WIDTH-1:0]           from_idx_i,
    output logic [$clog2(VECTOR_SIZE)-1:0] next_idx_o,
    output logic                           none_left_o
);

    // Scan downwards so the lowest qualifying index is the one left standing.
    // Lengths above VECTOR_SIZE clamp naturally since i never reaches them.
    always_comb begin
        next_idx_o  = '0;
        none_left_o = 1'b1;
        for (int i = int'(VECTOR_SIZE) - 1; i >= 0; i--) begin
            if (mask_i[i] && (i < int'(length_i)) && (i >= int'(from_idx_i))) begin
                next_idx_o  = ($clog2(VECTOR_SIZE))'(i);
                none_left_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/vector_data_cache.sv
// Single-line write-through vector data cache. Tag is {base, stride}; each element
// of the line has its own valid bit. Misses and stores go to memory one beat per
// active element.
module vector_data_cache
    import vector_data_cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 17,
    parameter int unsigned LEN         = 32,
    parameter int unsigned VECTOR_SIZE = 8,
    parameter int unsigned LEN_WIDTH   = $clog2(VECTOR_SIZE) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_access_enabled,
    input  logic [1:0]                  d_cache_vis_signal,
    input  logic [ADDR_WIDTH-1:0]       data_addr,
    input  logic [ADDR_WIDTH-1:0]       stride,
    input  logic [LEN_WIDTH-1:0]        length,
    input  logic [VECTOR_SIZE-1:0]      mask,
    input  logic [LEN*VECTOR_SIZE-1:0]  writen_vector_data,
    output logic [LEN*VECTOR_SIZE-1:0]  vector_data,
    output logic [1:0]                  mem_vis_status,
    input  logic [LEN-1:0]              mem_data,
    input  logic [1:0]                  mem_status,
    output logic [LEN-1:0]              mem_writen_data,
    output logic [ADDR_WIDTH-1:0]       mem_vis_addr,
    output logic [1:0]                  mem_vis_signal
);

    localparam int unsigned IdxW  = $clog2(VECTOR_SIZE);
    localparam int unsigned LineW = LEN * VECTOR_SIZE;

    vdc_state_e state_q, state_d;
    logic [1:0]             op_q, op_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d, stride_q, stride_d;
    logic [ADDR_WIDTH-1:0]  tag_base_q, tag_base_d, tag_stride_q, tag_stride_d;
    logic [VECTOR_SIZE-1:0] mask_q, mask_d, valid_q, valid_d;
    logic [LEN_WIDTH-1:0]   length_q, length_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [LineW-1:0]       line_q, line_d, wdata_q, wdata_d, vdata_q, vdata_d;
    logic [1:0]             mem_sig_q, mem_sig_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [LEN-1:0]         mem_wdata_q, mem_wdata_d;

    logic [VECTOR_SIZE-1:0] act_in, act_q, sel_mask;
    logic [LEN_WIDTH-1:0]   sel_len, sel_from;
    logic [IdxW-1:0]        sel_idx;
    logic                   sel_none, tag_match, hit, is_load, is_store;
    int                     lane_off;

    // Element 0 sits in the MSBs of every line-wide vector.
    function automatic logic [LineW-1:0] lane_fill(input logic [VECTOR_SIZE-1:0] act);
        logic [LineW-1:0] m;
        for (int i = 0; i < int'(VECTOR_SIZE); i++) begin
            m[(int'(VECTOR_SIZE) - 1 - i) * int'(LEN) +: LEN] = {LEN{act[i]}};
        end
        return m;
    endfunction

    function automatic logic [VECTOR_SIZE-1:0] active_lanes(input logic [VECTOR_SIZE-1:0] m,
                                                            input logic [LEN_WIDTH-1:0] len);
        logic [VECTOR_SIZE-1:0] a;
        for (int i = 0; i < int'(VECTOR_SIZE); i++) begin
            a[i] = m[i] && (i < int'(len));
        end
        return a;
    endfunction

    assign act_in    = active_lanes(mask, length);
    assign act_q     = active_lanes(mask_q, length_q);
    assign tag_match = (tag_base_q == data_addr) && (tag_stride_q == stride);
    assign hit       = tag_match && ((valid_q & act_in) == act_in);
    assign is_load   = (d_cache_vis_signal == D_CACHE_LOAD);
    assign is_store  = (d_cache_vis_signal == D_CACHE_STORE);
    assign lane_off  = (int'(VECTOR_SIZE) - 1 - int'(idx_q)) * int'(LEN);

    // In IDLE search the incoming request from 0; otherwise search past the current beat.
    assign sel_mask = (state_q == StIdle) ? mask : mask_q;
    assign sel_len  = (state_q == StIdle) ? length : length_q;
    assign sel_from = (state_q == StIdle) ? '0 : LEN_WIDTH'(idx_q) + LEN_WIDTH'(1);

    vdc_elem_sel #(
        .VECTOR_SIZE (VECTOR_SIZE),
        .LEN_WIDTH   (LEN_WIDTH)
    ) u_elem_sel (
        .mask_i      (sel_mask),
        .length_i    (sel_len),
        .from_idx_i  (sel_from),
        .next_idx_o  (sel_idx),
        .none_left_o (sel_none)
    );

    // Next-state, line update and memory-request logic.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        base_d       = base_q;
        stride_d     = stride_q;
        mask_d       = mask_q;
        length_d     = length_q;
        idx_d        = idx_q;
        tag_base_d   = tag_base_q;
        tag_stride_d = tag_stride_q;
        valid_d      = valid_q;
        line_d       = line_q;
        wdata_d      = wdata_q;
        vdata_d      = vdata_q;
        mem_sig_d    = mem_sig_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            StIdle: begin
                if (mem_access_enabled) begin
                    op_d     = d_cache_vis_signal;
                    base_d   = data_addr;
                    stride_d = stride;
                    mask_d   = mask;
                    length_d = length;
                    wdata_d  = writen_vector_data;
                    if (!(is_load || is_store) || sel_none) begin
                        state_d = StDone;
                    end else if (is_load && hit) begin
                        vdata_d = line_q & lane_fill(act_in);
                        state_d = StDone;
                    end else begin
                        idx_d   = sel_idx;
                        state_d = StReq;
                        if (is_load || !tag_match) begin
                            tag_base_d   = data_addr;
                            tag_stride_d = stride;
                            valid_d      = '0;
                        end
                        if (is_store) begin
                            for (int i = 0; i < int'(VECTOR_SIZE); i++) begin
                                if (act_in[i]) begin
                                    line_d[(int'(VECTOR_SIZE) - 1 - i) * int'(LEN) +: LEN] =
                                        writen_vector_data[(int'(VECTOR_SIZE) - 1 - i) *
                                                           int'(LEN) +: LEN];
                                end
                            end
                            valid_d = valid_d | act_in;
                        end
                    end
                end
            end
            StReq: begin
                if (mem_status == MEM_RESTING) begin
                    mem_addr_d = base_q + ADDR_WIDTH'(idx_q) * stride_q;
                    if (op_q == D_CACHE_LOAD) begin
                        mem_sig_d = MEM_READ;
                    end else begin
                        mem_sig_d   = MEM_WRITE;
                        mem_wdata_d = wdata_q[lane_off +: LEN];
                    end
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem_status == MEM_FINISHED) begin
                    if (op_q == D_CACHE_LOAD) begin
                        line_d[lane_off +: LEN] = mem_data;
                        valid_d[idx_q]          = 1'b1;
                    end
                    mem_sig_d = MEM_NOP;
                    if (!sel_none) begin
                        idx_d   = sel_idx;
                        state_d = StReq;
                    end else begin
                        state_d = (op_q == D_CACHE_LOAD) ? StFill : StDone;
                    end
                end
            end
            StFill: begin
                vdata_d = line_q & lane_fill(act_q);
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Status seen by the load/store unit follows the state and live memory status.
    always_comb begin
        mem_vis_status = D_CACHE_RESTING;
        case (state_q)
            StReq:   mem_vis_status = (mem_status == MEM_RESTING) ? D_CACHE_WORKING
                                                                  : D_CACHE_STALL;
            StWait,
            StFill:  mem_vis_status = D_CACHE_WORKING;
            StDone:  mem_vis_status = L_S_FINISHED;
            default: mem_vis_status = D_CACHE_RESTING;
        endcase
    end

    // State registers; reset drops any in-flight burst and invalidates the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            op_q         <= '0;
            base_q       <= '0;
            stride_q     <= '0;
            mask_q       <= '0;
            length_q     <= '0;
            idx_q        <= '0;
            tag_base_q   <= '0;
            tag_stride_q <= '0;
            valid_q      <= '0;
            line_q       <= '0;
            wdata_q      <= '0;
            vdata_q      <= '0;
            mem_sig_q    <= MEM_NOP;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            base_q       <= base_d;
            stride_q     <= stride_d;
            mask_q       <= mask_d;
            length_q     <= length_d;
            idx_q        <= idx_d;
            tag_base_q   <= tag_base_d;
            tag_stride_q <= tag_stride_d;
            valid_q      <= valid_d;
            line_q       <= line_d;
            wdata_q      <= wdata_d;
            vdata_q      <= vdata_d;
            mem_sig_q    <= mem_sig_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign vector_data     = vdata_q;
    assign mem_vis_signal  = mem_sig_q;
    assign mem_vis_addr    = mem_addr_q;
    assign mem_writen_data = mem_wdata_q;

endmodule

// File: doc/vector_data_cache.md
Name: vector_data_cache

Overview:
- Parametrised single-line vector data cache between the load/store unit and main memory.
- Serves unit-stride and strided vector loads/stores of up to VECTOR_SIZE elements, with a per-element mask.
- Memory traffic is one 32-bit beat per active element, issued element by element.
- Write-through. Loads hit when tag (base, stride) matches and every active element is valid.

Parameters:
ADDR_WIDTH, 17, byte address width
LEN, 32, element width in bits
VECTOR_SIZE, 8, max elements per access (power of two, >=2)
LEN_WIDTH, $clog2(VECTOR_SIZE)+1, width of length field (encodes 0..VECTOR_SIZE)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
mem_access_enabled  in  1  request strobe, sampled in IDLE only
d_cache_vis_signal  in  2  D_CACHE_NOP/LOAD/STORE
data_addr  in  ADDR_WIDTH  base byte address
stride  in  ADDR_WIDTH  signed byte stride between elements
length  in  LEN_WIDTH  element count
mask  in  VECTOR_SIZE  bit i=1: element i active
writen_vector_data  in  LEN*VECTOR_SIZE  store data, element 0 in MSBs
vector_data  out  LEN*VECTOR_SIZE  load result, element 0 in MSBs
mem_vis_status  out  2  D_CACHE_RESTING/WORKING/STALL, L_S_FINISHED
mem_data  in  LEN  read data from memory
mem_status  in  2  MEM_RESTING/MEM_WORKING/MEM_FINISHED
mem_writen_data  out  LEN  write data
mem_vis_addr  out  ADDR_WIDTH  access address
mem_vis_signal  out  2  MEM_NOP/MEM_READ/MEM_WRITE

Behaviour:
- Reset (async, any state, mid-burst included): state IDLE; all valid bits 0; tag cleared; vector_data 0; mem_vis_status D_CACHE_RESTING; mem_vis_signal MEM_NOP; mem_vis_addr 0; mem_writen_data 0.
- Active element i: i < length and mask[i]=1.
- Address of element i: data_addr + i*stride, modulo 2^ADDR_WIDTH (wrap, no error).
- States and transitions:
- IDLE: if mem_access_enabled, latch request.
  - NOP, or no active element (length==0 or mask all 0): go DONE.
  - LOAD hit (tag == {data_addr, stride} and valid set for all active i): copy line into vector_data with inactive lanes zeroed; go DONE. Latency 2 cycles.
  - Otherwise: set index to the first active element; go REQ.
  - LOAD miss: retag to {data_addr, stride} and clear all valid bits.
  - STORE, tag mismatch: retag and clear all valid bits.
  - STORE, tag match: keep tag and valid bits.
  - In both STORE cases, write active lanes into the line and set their valid bits in this cycle.
- REQ: if mem_status != MEM_RESTING, hold MEM_NOP with status D_CACHE_STALL. Otherwise drive element address, MEM_READ or MEM_WRITE (plus mem_writen_data), status D_CACHE_WORKING; go WAIT.
- WAIT: hold signal/address/data until mem_status==MEM_FINISHED.
  - LOAD: capture mem_data into line[index] and set valid[index].
  - Then drive MEM_NOP. If another active element remains, jump index to it (inactive elements generate no traffic) and go REQ; else go FILL (load) or DONE (store).
- FILL: vector_data <= line, inactive lanes zeroed; go DONE.
- DONE: mem_vis_status L_S_FINISHED for exactly one cycle; then IDLE with D_CACHE_RESTING.
- vector_data holds its value except in the hit and FILL updates.
- Requests arriving outside IDLE are ignored.
- length > VECTOR_SIZE is clamped to VECTOR_SIZE.

Decomposition:
- Add to the shared defines file: D_CACHE_* request/status codes and MEM_* signal/status codes (including MEM_FINISHED).
- Sub-module vdc_elem_sel: combinational next-active-index finder. Inputs: mask, length, current index. Outputs: next index and none-left flag.

Test Plan:
- Reset, then LOAD base 0x100, stride 4, length 8, mask 0xFF, memory word = address -> 8 MEM_READs at 0x100..0x11C; vector_data lanes 0x100..0x11C; L_S_FINISHED pulse once.
- Repeat the identical LOAD -> no memory traffic; L_S_FINISHED on the 2nd cycle; same data.
- STORE base 0x200, stride -8, length 4, mask 0b1010 (elements 1, 3 active) -> exactly two MEM_WRITEs, at 0x1F8 and 0x1E8.
- LOAD base 0x1FFFC, stride 4, length 2 -> addresses 0x1FFFC then 0x00000 (wrap).
- mem_status held MEM_WORKING for 5 cycles at REQ -> D_CACHE_STALL with MEM_NOP for those cycles, then the access proceeds.
- Assert rst during the 3rd beat of an 8-element load -> outputs immediately at reset values; the following identical LOAD misses and reissues all 8 reads.
